mem_xfer_unit: RTL

MEM_XFER_UNIT -- requirements
Module: mem_xfer_unit

---
 rtl/mem_xfer_pkg.sv | 20 ++
 rtl/xfer_wait_counter.sv | 36 +++
 rtl/mem_xfer_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types and default sizing for the memory transfer unit.
//   xfer_state_e    : controller states (IDLE, ACCESS, DONE)
//   DEF_DATA_W      : default MDR / memory data width
//   DEF_ADDR_W      : default MAR / memory address width
//   DEF_WAIT_CYCLES : default number of ACCESS cycles per transaction
//   WAIT_CNT_W      : wait counter width, wide enough for the 1..15 range
package mem_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } xfer_state_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/xfer_wait_counter.sv
// Up-counter that times the ACCESS phase of a memory transaction.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset, counter -> 0
//   clr_i : synchronous clear to 0 (priority over en_i)
//   en_i  : count up by one per cycle
//   tc_o  : high while the count equals TERMINAL
module xfer_wait_counter
    import mem_xfer_pkg::*;
#(
    parameter int CNT_W    = WAIT_CNT_W,
    parameter int TERMINAL = DEF_WAIT_CYCLES - 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_xfer_unit.sv
// Memory transfer unit: MAR/MDR register pair plus a three-state controller
// that runs fixed-length read or write accesses on a simple memory bus.
//   Clk, Reset           : clock (rising edge), async active-high reset
//   LD_MAR, MAR_in       : load address register (IDLE only)
//   LD_MDR, MIO_EN       : load data register from Mem_rdata (MIO_EN=1)
//   MDR_Datapath         :   or from the datapath (MIO_EN=0), IDLE only
//   Start, RW            : begin a transaction; RW=1 write, RW=0 read
//   Mem_rdata            : memory read data
//   Mem_addr, Mem_wdata  : MAR / MDR driven onto the memory bus
//   Mem_CE/WE/OE         : memory strobes, high during ACCESS
//   Busy, Done           : not-IDLE flag, one-cycle completion pulse
//   MAR_out, MDR_out     : register contents
module mem_xfer_unit
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES   // legal range 1..15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic [ADDR_W-1:0] MAR_in,
    input  logic [DATA_W-1:0] MDR_Datapath,
    input  logic              Start,
    input  logic              RW,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              Mem_CE,
    output logic              Mem_WE,
    output logic              Mem_OE,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MDR_out
);

    xfer_state_e       state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              cnt_clr, cnt_en, cnt_tc;

    xfer_wait_counter #(
        .CNT_W    (WAIT_CNT_W),
        .TERMINAL (WAIT_CYCLES - 1)
    ) u_wait_cnt (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Register loads and Start share the cycle, so a transaction
                // started here already uses the freshly loaded MAR/MDR.
                if (LD_MAR) begin
                    mar_d = MAR_in;
                end
                if (LD_MDR) begin
                    mdr_d = MIO_EN ? Mem_rdata : MDR_Datapath;
                end
                if (Start) begin
                    rw_d    = RW;
                    cnt_clr = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    // Read data is captured on the last ACCESS edge, while
                    // OE is still asserted.
                    if (!rw_q) begin
                        mdr_d = Mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes come straight from registers so reset clears them at once.
    assign Mem_CE    = (state_q == ST_ACCESS);
    assign Mem_WE    = (state_q == ST_ACCESS) &&  rw_q;
    assign Mem_OE    = (state_q == ST_ACCESS) && !rw_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);

    assign Mem_addr  = mar_q;
    assign Mem_wdata = mdr_q;
    assign MAR_out   = mar_q;
    assign MDR_out   = mdr_q;

endmodule
